fpu_rr_arbiter: RTL and testbench
=================================

Name: fpu_rr_arbiter

Overview:
Round-robin arbiter/scheduler that shares one floating_point_unit among NUM_REQ requesters. It accepts operand pairs through per-requester valid/ready handshakes and issues at most one operation per cycle through a registered issue stage. It tracks in-flight operations with a fixed-latency tag pipeline and returns each result to the requester that issued it. It sits between the TTPU compute requesters and the shared FPU instance.

Parameters:
DATA_WIDTH, 16, operand/result width (FP16)
NUM_REQ, 4, number of requesters (>=1)
FPU_LATENCY, 1, cycles from the edge where the FPU samples en=1 to a valid result

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
hold  in  1  1 = suppress new grants; in-flight ops still complete
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester grant, one-hot or zero
req_dec  in  NUM_REQ  per-requester dec bit, forwarded unchanged to the FPU
req_a  in  NUM_REQ*DATA_WIDTH  packed operand A, requester i at [i*DW +: DW]
req_b  in  NUM_REQ*DATA_WIDTH  packed operand B
rsp_valid  out  NUM_REQ  one-hot result strobe, no backpressure
rsp_data  out  DATA_WIDTH  result; meaningful only when |rsp_valid
fpu_en  out  1  FPU enable (registered)
fpu_dec  out  1  FPU dec (registered)
fpu_a  out  DATA_WIDTH  FPU operand A (registered)
fpu_b  out  DATA_WIDTH  FPU operand B (registered)
fpu_result  in  DATA_WIDTH  FPU result
idle  out  1  no op issued or in flight

Behaviour:
- Reset: rr_ptr=0; fpu_en=0; fpu_dec=0; fpu_a=0; fpu_b=0; tag pipeline cleared; rsp_valid=0; idle=1. Reset mid-operation drops all in-flight ops: no rsp_valid for them after reset.
- Grant (combinational): when hold=0, grant goes to the first i with req_valid[i]=1, scanning cyclically from rr_ptr. req_ready=grant. A transfer occurs when req_valid[i]&&req_ready[i]. req_ready never asserts when req_valid is low.
- Pointer update: on a transfer to i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds. With NUM_REQ=1, rr_ptr stays 0.
- Issue: a transfer in cycle T loads fpu_a, fpu_b and fpu_dec from requester i and sets fpu_en=1, all visible in T+1. With no transfer, fpu_en=0 and the operand/dec registers hold their last values.
- Tag pipeline: shift register of FPU_LATENCY+1 entries of {valid, id}, advancing every cycle. An entry enters at T and exits at T+1+FPU_LATENCY.
- Response: at exit, rsp_valid[id]=1 and rsp_data=fpu_result (combinational passthrough). Request-to-response latency is FPU_LATENCY+1 cycles. Throughput is 1 op/cycle. Responses return in issue order.
- idle = !fpu_en && no valid tag entry && no transfer this cycle.
- hold asserted mid-stream: the current cycle grants nothing. Ops already registered or in flight complete normally.
- Simultaneous transfer and response in the same cycle is legal and must not interfere.

Optional Feature:
FPU_ARB_STATS_EN
- Defined: adds input stat_clear (1 bit) and output stat_grant_cnt (NUM_REQ*16). Each requester has a 16-bit saturating counter that increments on each of its transfers and saturates at 16'hFFFF. stat_clear or reset zeroes all counters. If stat_clear coincides with a transfer, the clear wins.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Decomposition:
- Package fpu_arb_pkg: STAT_CNT_W=16; tag typedef {logic vld; logic [ID_W-1:0] id}; function computing ID_W=$clog2(NUM_REQ) with a minimum of 1.
- Sub-module rr_arb_picker: purely combinational; inputs req vector, rr_ptr, hold; outputs one-hot grant and encoded grant_id. Reusable for other shared TTPU resources.

Test Plan:
1. Reset, then FPU_LATENCY=1. At cycle T, requester 0 sends a=16'h4200, b=16'hC600, dec=0 -> req_ready=4'b0001 at T. At T+1: fpu_en=1, fpu_a=16'h4200, fpu_b=16'hC600. At T+2: rsp_valid=4'b0001 and rsp_data=fpu_result.
2. All 4 requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. rsp_valid follows the same order, 2 cycles later, back-to-back.
3. rr_ptr=2, only requesters 1 and 3 valid -> grant 3 first, then 1. rr_ptr ends at 2.
4. hold=1 with all requesters valid and 2 ops in flight -> req_ready=0 and fpu_en=0 from the next cycle. Both in-flight responses still arrive. idle=1 afterwards.
5. reset pulsed for one cycle while 2 ops are in flight -> rsp_valid=0 in every following cycle until a new transfer. All outputs hold their reset values.
6. FPU_ARB_STATS_EN: 3 transfers from requester 2 -> count[2]=3. Pulse stat_clear -> 0. Force 70000 transfers -> count holds 16'hFFFF.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// rtl/fpu_arb_pkg.sv - shared constants and helpers for the FPU round-robin arbiter
package fpu_arb_pkg;

  localparam int STAT_CNT_W = 16;

  // Requester id width; a single requester still needs one bit to carry an id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_picker.sv
// rtl/rr_arb_picker.sv - combinational round-robin picker: first requester at or after rr_ptr wins
module rr_arb_picker
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!hold && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - round-robin sharing of one FPU with a fixed-latency result tag pipeline
// Optional FPU_ARB_STATS_EN adds stat_clear and per-requester saturating grant counters.
module fpu_rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_dec,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          fpu_en,
  output logic                          fpu_dec,
  output logic [DATA_WIDTH-1:0]         fpu_a,
  output logic [DATA_WIDTH-1:0]         fpu_b,
  input  logic [DATA_WIDTH-1:0]         fpu_result,
  output logic                          idle
`ifdef FPU_ARB_STATS_EN
  ,
  input  logic                          stat_clear,
  output logic [NUM_REQ*STAT_CNT_W-1:0] stat_grant_cnt
`endif
);

  localparam int ID_W   = id_width(NUM_REQ);
  localparam int PIPE_D = FPU_LATENCY + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic                  transfer;
  logic                  any_tag_vld;

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  fpu_en_q, fpu_en_d;
  logic                  fpu_dec_q, fpu_dec_d;
  logic [DATA_WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [DATA_WIDTH-1:0] fpu_b_q, fpu_b_d;
  tag_t                  tag_q [PIPE_D];
  tag_t                  tag_d [PIPE_D];

  rr_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req      (req_valid),
    .rr_ptr   (rr_ptr_q),
    .hold     (hold),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    fpu_en_d  = 1'b0;
    fpu_dec_d = fpu_dec_q;
    fpu_a_d   = fpu_a_q;
    fpu_b_d   = fpu_b_q;
    if (transfer) begin
      rr_ptr_d  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      fpu_en_d  = 1'b1;
      fpu_dec_d = req_dec[grant_id];
      fpu_a_d   = req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      fpu_b_d   = req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage 0 mirrors the issue register; the last stage lines up with a valid fpu_result.
  always_comb begin
    tag_d[0].vld = transfer;
    tag_d[0].id  = grant_id;
    for (int k = 1; k < PIPE_D; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    rsp_valid   = '0;
    any_tag_vld = 1'b0;
    if (tag_q[PIPE_D-1].vld) begin
      rsp_valid[tag_q[PIPE_D-1].id] = 1'b1;
    end
    for (int k = 0; k < PIPE_D; k++) begin
      any_tag_vld = any_tag_vld | tag_q[k].vld;
    end
  end

  assign rsp_data = fpu_result;
  assign idle     = !fpu_en_q && !any_tag_vld && !transfer;
  assign fpu_en   = fpu_en_q;
  assign fpu_dec  = fpu_dec_q;
  assign fpu_a    = fpu_a_q;
  assign fpu_b    = fpu_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      fpu_en_q  <= 1'b0;
      fpu_dec_q <= 1'b0;
      fpu_a_q   <= '0;
      fpu_b_q   <= '0;
      for (int k = 0; k < PIPE_D; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      fpu_en_q  <= fpu_en_d;
      fpu_dec_q <= fpu_dec_d;
      fpu_a_q   <= fpu_a_d;
      fpu_b_q   <= fpu_b_d;
      for (int k = 0; k < PIPE_D; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

`ifdef FPU_ARB_STATS_EN
  logic [STAT_CNT_W-1:0] stat_cnt_q [NUM_REQ];
  logic [STAT_CNT_W-1:0] stat_cnt_d [NUM_REQ];

  // Clear takes priority over a coincident grant.
  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
      if (stat_clear) begin
        stat_cnt_d[i] = '0;
      end else if (grant[i] && (stat_cnt_q[i] != '1)) begin
        stat_cnt_d[i] = stat_cnt_q[i] + STAT_CNT_W'(1);
      end
      stat_grant_cnt[i*STAT_CNT_W +: STAT_CNT_W] = stat_cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        stat_cnt_q[i] <= '0;
      end else begin
        stat_cnt_q[i] <= stat_cnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// tb/tb_fpu_rr_arbiter.sv - self-checking bench for fpu_rr_arbiter against a queue-based reference model
module tb_fpu_rr_arbiter;

  localparam int DW  = 16;
  localparam int NR  = 4;
  localparam int LAT = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             hold = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_dec = '0;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             fpu_en, fpu_dec;
  logic [DW-1:0]    fpu_a, fpu_b;
  logic [DW-1:0]    fpu_result = '0;
  logic             idle;
`ifdef FPU_ARB_STATS_EN
  logic             stat_clear = 1'b0;
  logic [NR*16-1:0] stat_grant_cnt;
`endif

  always #5 clk = ~clk;

  fpu_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FPU_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dec    (req_dec),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .fpu_en     (fpu_en),
    .fpu_dec    (fpu_dec),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .idle       (idle)
`ifdef FPU_ARB_STATS_EN
    ,
    .stat_clear     (stat_clear),
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  // Stand-in one-cycle FPU: integer add, or subtract when dec is set.
  function automatic logic [DW-1:0] fpu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic dec);
    return dec ? (a - b) : (a + b);
  endfunction

  always @(posedge clk) if (fpu_en) fpu_result <= fpu_fn(fpu_a, fpu_b, fpu_dec);

  typedef struct {
    int            id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          dec;
    int            due;
  } op_t;

  op_t           pq[$];
  int            m_ptr = 0;
  int            cyc = 0;
  int            gsel = -1;
  logic          m_en = 1'b0, m_dec = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  int            total = 0;
  int            passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick();
    if (hold) return -1;
    for (int k = 0; k < NR; k++) begin
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic sample_check();
    logic [NR-1:0] er, ev;
    logic [DW-1:0] ed;
    bit            has;
    @(negedge clk);
    gsel = pick();
    er = '0;
    if (gsel >= 0) er[gsel] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("fpu_en", fpu_en, m_en);
    chk("fpu_a", fpu_a, m_a);
    chk("fpu_b", fpu_b, m_b);
    chk("fpu_dec", fpu_dec, m_dec);
    chk("idle", idle, (!m_en && pq.size() == 0 && gsel < 0));
    ev = '0; ed = '0; has = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      ev[pq[0].id] = 1'b1;
      ed = fpu_fn(pq[0].a, pq[0].b, pq[0].dec);
      has = 1;
      void'(pq.pop_front());
    end
    chk("rsp_valid", rsp_valid, ev);
    if (has) chk("rsp_data", rsp_data, ed);
  endtask

  task automatic advance();
    op_t o;
    @(posedge clk);
    if (gsel >= 0) begin
      o.id  = gsel;
      o.a   = req_a[gsel*DW +: DW];
      o.b   = req_b[gsel*DW +: DW];
      o.dec = req_dec[gsel];
      o.due = cyc + 1 + LAT;
      pq.push_back(o);
      m_en = 1'b1; m_a = o.a; m_b = o.b; m_dec = o.dec;
      m_ptr = (gsel + 1) % NR;
    end else begin
      m_en = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    sample_check();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pq.delete();
    m_ptr = 0; m_en = 1'b0; m_dec = 1'b0; m_a = '0; m_b = '0;
    cyc++;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = DW'($urandom);
      req_b[i*DW +: DW] = DW'($urandom);
    end
    req_dec = NR'($urandom);
  endtask

  initial begin
    // Reset state
    do_reset();
    step();
    chk("rst_idle", idle, 1'b1);

    // Single op from requester 0
    req_valid = 4'b0001; req_dec = '0;
    req_a[0 +: DW] = 16'h4200; req_b[0 +: DW] = 16'hC600;
    sample_check(); chk("t1_ready", req_ready, 4'b0001); advance();
    req_valid = '0;
    sample_check(); chk("t1_en", fpu_en, 1'b1); chk("t1_a", fpu_a, 16'h4200); chk("t1_b", fpu_b, 16'hC600); advance();
    sample_check(); chk("t1_rsp", rsp_valid, 4'b0001); chk("t1_data", rsp_data, 16'h0800); advance();
    step();

    // All valid: strict rotation, back-to-back responses
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      sample_check(); chk("t2_order", req_ready, 4'b0001 << (k % 4)); advance();
    end
    req_valid = '0;
    repeat (3) step();

    // Pointer at 2 with only 1 and 3 valid
    do_reset();
    req_valid = 4'b0010; step();
    req_valid = 4'b1010;
    sample_check(); chk("t3_first", req_ready, 4'b1000); advance();
    sample_check(); chk("t3_second", req_ready, 4'b0010); advance();
    req_valid = 4'b1111;
    sample_check(); chk("t3_ptr", req_ready, 4'b0100); advance();
    req_valid = '0;
    repeat (3) step();

    // Hold with two ops in flight
    do_reset();
    req_valid = 4'b1111; rand_ops();
    step(); step();
    hold = 1'b1;
    sample_check(); chk("t4_ready", req_ready, 4'b0000); advance();
    sample_check(); chk("t4_en", fpu_en, 1'b0); advance();
    sample_check(); chk("t4_idle", idle, 1'b1); advance();
    hold = 1'b0; req_valid = '0;

    // Reset with two ops in flight
    do_reset();
    req_valid = 4'b1111; rand_ops();
    step(); step();
    req_valid = '0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sample_check(); chk("t5_rsp", rsp_valid, 4'b0000); chk("t5_a", fpu_a, 16'h0000); advance();
    end

    // Randomized traffic with occasional hold and reset
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid = NR'($urandom);
      hold = ($urandom_range(9) == 0);
      rand_ops();
      if ($urandom_range(99) == 0) do_reset();
      else step();
    end
    req_valid = '0; hold = 1'b0;
    repeat (4) step();
    chk("rand_idle", idle, 1'b1);

`ifdef FPU_ARB_STATS_EN
    do_reset();
    req_valid = 4'b0100;
    repeat (3) step();
    req_valid = '0;
    sample_check(); chk("st_cnt3", stat_grant_cnt[2*16 +: 16], 16'd3); advance();
    stat_clear = 1'b1; step(); stat_clear = 1'b0;
    sample_check(); chk("st_clear", stat_grant_cnt[2*16 +: 16], 16'd0); advance();
    req_valid = 4'b0100;
    repeat (70000) @(posedge clk);
    #1;
    chk("st_sat", stat_grant_cnt[2*16 +: 16], 16'hFFFF);
    req_valid = '0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
